// File: rtl/updown_counter_ctrl_if.sv
// rtl/updown_counter_ctrl_if.sv - command handshake bundle for the up/down counter sequencer
interface updown_counter_ctrl_if #(
    parameter int WIDTH   = 4,
    parameter int STEPS_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [WIDTH-1:0]   cmd_data;
    logic [STEPS_W-1:0] cmd_steps;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/updown_counter_ctrl.sv
// rtl/updown_counter_ctrl.sv - LOAD/UP/DOWN command sequencer driving a 4-bit up/down counter
module updown_counter_ctrl #(
    parameter int WIDTH   = 4,
    parameter int STEPS_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    updown_counter_ctrl_if.slave cmd,
    input  logic                 abort,
    output logic                 ctr_load,
    output logic                 ctr_up_down,
    output logic                 ctr_enable,
    output logic [WIDTH-1:0]     ctr_d_in,
    input  logic [WIDTH-1:0]     ctr_count,
    output logic                 busy,
    output logic                 done,
    output logic                 wrapped,
    output logic                 aborted,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    state_t             state;
    state_t             state_nx;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   data_q;
    logic [STEPS_W-1:0] remaining;
    logic               wrapped_q;
    logic               aborted_q;
    logic               err_q;
    logic               accept;
    logic               step_wraps;

    assign accept = (state == S_IDLE) && cmd.cmd_valid;

    // Wrap is judged on the value the counter holds before the step is taken.
    assign step_wraps = ((op_q == OP_UP)   && (ctr_count == {WIDTH{1'b1}})) ||
                        ((op_q == OP_DOWN) && (ctr_count == {WIDTH{1'b0}}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd.cmd_op == OP_LOAD) begin
                        state_nx = S_LOAD;
                    end else if (cmd.cmd_op == 2'b11 || cmd.cmd_steps == '0) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_RUN;
                    end
                end
            end
            S_LOAD:  state_nx = S_DONE;
            S_RUN: begin
                if (abort || remaining == STEPS_W'(1)) begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 2'b00;
            data_q    <= '0;
            remaining <= '0;
            wrapped_q <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (accept) begin
            op_q      <= cmd.cmd_op;
            data_q    <= cmd.cmd_data;
            remaining <= cmd.cmd_steps;
            wrapped_q <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= (cmd.cmd_op == 2'b11);
        end else if (state == S_RUN) begin
            if (abort) begin
                aborted_q <= 1'b1;
            end else begin
                remaining <= remaining - STEPS_W'(1);
                if (step_wraps) begin
                    wrapped_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        cmd.cmd_ready = (state == S_IDLE);
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        ctr_load      = (state == S_LOAD);
        ctr_enable    = (state == S_RUN) && !abort;
        ctr_up_down   = (op_q == OP_UP);
        ctr_d_in      = data_q;
        wrapped       = wrapped_q;
        aborted       = aborted_q;
        err           = err_q;
    end

endmodule
